sprite_blitter: RTL and testbench

- Hardware draw engine for the DXYN instruction. The cpu gives it a coordinate, a row count and the I register.
- It fetches sprite bytes from ram and read-modify-writes the 128x64x2-bit vram.
- It is the writer on the vram pixel port; vdrive_studio is the reader on the other vram port.
- It reports busy, done and collision (VF) back to the cpu.

---
 rtl/sprite_blitter_if.sv | 48 ++++
 rtl/sprite_blitter.sv | 207 ++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// ============================================================================
// Module      : sprite_blitter_if
// Description : Bundles the draw command, status, sprite-RAM and VRAM pixel
//               port signals of the sprite blitter.
//               slave  - the blitter's view of the bundle.
//               master - the view of the cpu / memory side.
// Ports (signals):
//   start, x[7], y[6], n[4], i_addr[12], plane_mask[2] : draw command
//   busy, done, collision                               : status to cpu
//   ram_addr[12], ram_dout[8]                           : sprite byte fetch
//   vram_hpos[7], vram_vpos[6], vram_rd[2], vram_wr[2],
//   vram_we                                             : vram pixel port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_blitter_if;
  logic        start;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [3:0]  n;
  logic [11:0] i_addr;
  logic [1:0]  plane_mask;
  logic        busy;
  logic        done;
  logic        collision;
  logic [11:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [6:0]  vram_hpos;
  logic [5:0]  vram_vpos;
  logic [1:0]  vram_rd;
  logic [1:0]  vram_wr;
  logic        vram_we;

  modport slave (
    input  start, x, y, n, i_addr, plane_mask, ram_dout, vram_rd,
    output busy, done, collision, ram_addr, vram_hpos, vram_vpos,
           vram_wr, vram_we
  );

  modport master (
    output start, x, y, n, i_addr, plane_mask, ram_dout, vram_rd,
    input  busy, done, collision, ram_addr, vram_hpos, vram_vpos,
           vram_wr, vram_we
  );
endinterface

`default_nettype wire

// File: rtl/sprite_blitter.sv
// ============================================================================
// Module      : sprite_blitter
// Description : DXYN draw engine. Fetches sprite rows from ram and XORs each
//               set bit into the selected bit planes of the 2-bit vram with a
//               read-modify-write, reporting busy, done and collision.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-low reset
//   bus   - sprite_blitter_if.slave (command, status, ram and vram ports)
// Parameters:
//   HRES, VRES - screen size in pixels (powers of two, at most 128 x 64)
//   CLIP       - 1: drop pixels past the right/bottom edge, 0: wrap them
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_blitter #(
  parameter int HRES = 128,
  parameter int VRES = 64,
  parameter int CLIP = 1
) (
  input  logic            clk,
  input  logic            reset,
  sprite_blitter_if.slave bus
);

  localparam logic [6:0] C_XMASK = 7'(HRES - 1);
  localparam logic [5:0] C_YMASK = 6'(VRES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FADDR  = 3'd1,
    S_FLATCH = 3'd2,
    S_SCAN   = 3'd3,
    S_PREAD  = 3'd4,
    S_PWRITE = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t      state_q;

  // Command latched at start
  logic [6:0]  x0_q;
  logic [5:0]  y0_q;
  logic        wide_q;
  logic [3:0]  last_row_q;
  logic [11:0] base_q;
  logic [1:0]  mask_q;

  // Scan position and row data; left byte lives in [15:8]
  logic [3:0]  row_q;
  logic [3:0]  col_q;
  logic        half_q;
  logic [15:0] shift_q;

  // Registered outputs
  logic        busy_q;
  logic        done_q;
  logic        coll_q;
  logic        we_q;
  logic [1:0]  wr_q;
  logic [11:0] raddr_q;
  logic [6:0]  hpos_q;
  logic [5:0]  vpos_q;

  // Screen column for sprite column col, reduced mod HRES
  function automatic logic [6:0] col_hpos(input logic [3:0] col);
    logic [7:0] sum;
    sum = {1'b0, x0_q} + {4'b0000, col};
    return sum[6:0] & C_XMASK;
  endfunction

  // Screen row for sprite row row, reduced mod VRES
  function automatic logic [5:0] row_vpos(input logic [3:0] row);
    logic [6:0] sum;
    sum = {1'b0, y0_q} + {3'b000, row};
    return sum[5:0] & C_YMASK;
  endfunction

  logic [7:0]  px_sum;
  logic [6:0]  py_sum;
  logic        off_edge;
  logic        bit_set;
  logic        skip_px;
  logic        last_col;
  logic        advance;
  logic [3:0]  row_nxt;
  logic [11:0] row_addr_nxt;

  always_comb begin
    px_sum       = {1'b0, x0_q} + {4'b0000, col_q};
    py_sum       = {1'b0, y0_q} + {3'b000, row_q};
    off_edge     = (px_sum > {1'b0, C_XMASK}) || (py_sum > {1'b0, C_YMASK});
    // Columns are taken MSB first: column c is bit 15-c, i.e. ~c.
    bit_set      = shift_q[~col_q];
    skip_px      = !bit_set || ((CLIP != 0) && off_edge);
    last_col     = wide_q ? (col_q == 4'd15) : (col_q == 4'd7);
    // A column finishes either by being skipped or after its write-back.
    advance      = (state_q == S_PWRITE) || ((state_q == S_SCAN) && skip_px);
    row_nxt      = row_q + 4'd1;
    row_addr_nxt = base_q + (wide_q ? {7'd0, row_nxt, 1'b0} : {8'd0, row_nxt});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      wide_q     <= 1'b0;
      last_row_q <= '0;
      base_q     <= '0;
      mask_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      half_q     <= 1'b0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
      we_q       <= 1'b0;
      wr_q       <= '0;
      raddr_q    <= '0;
      hpos_q     <= '0;
      vpos_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            x0_q       <= bus.x & C_XMASK;
            y0_q       <= bus.y & C_YMASK;
            wide_q     <= (bus.n == 4'd0);
            last_row_q <= (bus.n == 4'd0) ? 4'd15 : (bus.n - 4'd1);
            base_q     <= bus.i_addr;
            mask_q     <= bus.plane_mask;
            row_q      <= '0;
            half_q     <= 1'b0;
            raddr_q    <= bus.i_addr;
            coll_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_FADDR;
          end
        end
        S_FADDR: state_q <= S_FLATCH;
        S_FLATCH: begin
          if (half_q) shift_q[7:0]  <= bus.ram_dout;
          else        shift_q[15:8] <= bus.ram_dout;
          if (wide_q && !half_q) begin
            half_q  <= 1'b1;
            raddr_q <= raddr_q + 12'd1;
            state_q <= S_FADDR;
          end else begin
            col_q   <= '0;
            hpos_q  <= col_hpos(4'd0);
            vpos_q  <= row_vpos(row_q);
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!skip_px) state_q <= S_PREAD;
        end
        S_PREAD: begin
          wr_q <= bus.vram_rd ^ mask_q;
          if ((bus.vram_rd & mask_q) != 2'b00) coll_q <= 1'b1;
          we_q    <= 1'b1;
          state_q <= S_PWRITE;
        end
        S_PWRITE: we_q <= 1'b0;
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Column/row stepping shared by the skip path and the write-back path;
      // placed after the case so its state assignment takes precedence.
      if (advance) begin
        if (!last_col) begin
          col_q   <= col_q + 4'd1;
          hpos_q  <= col_hpos(col_q + 4'd1);
          state_q <= S_SCAN;
        end else if (row_q != last_row_q) begin
          row_q   <= row_nxt;
          half_q  <= 1'b0;
          raddr_q <= row_addr_nxt;
          state_q <= S_FADDR;
        end else begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.collision = coll_q;
  assign bus.ram_addr  = raddr_q;
  assign bus.vram_hpos = hpos_q;
  assign bus.vram_vpos = vpos_q;
  assign bus.vram_wr   = wr_q;
  assign bus.vram_we   = we_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_blitter.sv
// ============================================================================
// Module      : tb_sprite_blitter
// Description : Self-checking bench. Two blitters (CLIP=1 and CLIP=0) receive
//               the same commands; each has its own vram model, both share
//               one sprite ram. A pixel-level reference model predicts the
//               final screen, write count, collision and done latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_blitter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [3:0]  n;
  logic [11:0] i_addr;
  logic [1:0]  pmask;

  sprite_blitter_if b0 ();
  sprite_blitter_if b1 ();

  assign b0.start = start;  assign b1.start = start;
  assign b0.x = x;          assign b1.x = x;
  assign b0.y = y;          assign b1.y = y;
  assign b0.n = n;          assign b1.n = n;
  assign b0.i_addr = i_addr; assign b1.i_addr = i_addr;
  assign b0.plane_mask = pmask; assign b1.plane_mask = pmask;

  sprite_blitter #(.HRES(128), .VRES(64), .CLIP(1)) u_clip (
    .clk(clk), .reset(reset), .bus(b0.slave));
  sprite_blitter #(.HRES(128), .VRES(64), .CLIP(0)) u_wrap (
    .clk(clk), .reset(reset), .bus(b1.slave));

  // Memories: synchronous, one cycle read latency
  bit [7:0]    ram [4096];
  bit [1:0]    vm  [2][8192];
  bit [1:0]    em  [2][8192];
  int unsigned wcnt [2];

  always @(posedge clk) begin
    b0.ram_dout <= ram[b0.ram_addr];
    b1.ram_dout <= ram[b1.ram_addr];
    b0.vram_rd  <= vm[0][{b0.vram_vpos, b0.vram_hpos}];
    b1.vram_rd  <= vm[1][{b1.vram_vpos, b1.vram_hpos}];
    if (b0.vram_we) begin
      vm[0][{b0.vram_vpos, b0.vram_hpos}] <= b0.vram_wr;
      wcnt[0] <= wcnt[0] + 1;
    end
    if (b1.vram_we) begin
      vm[1][{b1.vram_vpos, b1.vram_hpos}] <= b1.vram_wr;
      wcnt[1] <= wcnt[1] + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  function automatic logic rd_busy(input int u); return (u == 0) ? b0.busy : b1.busy; endfunction
  function automatic logic rd_done(input int u); return (u == 0) ? b0.done : b1.done; endfunction
  function automatic logic rd_coll(input int u); return (u == 0) ? b0.collision : b1.collision; endfunction
  function automatic logic rd_we(input int u); return (u == 0) ? b0.vram_we : b1.vram_we; endfunction
  function automatic logic [11:0] rd_raddr(input int u); return (u == 0) ? b0.ram_addr : b1.ram_addr; endfunction
  function automatic logic [6:0] rd_hpos(input int u); return (u == 0) ? b0.vram_hpos : b1.vram_hpos; endfunction
  function automatic logic [5:0] rd_vpos(input int u); return (u == 0) ? b0.vram_vpos : b1.vram_vpos; endfunction

  function automatic int vram_diff(input int u);
    int d = 0;
    for (int i = 0; i < 8192; i++) if (vm[u][i] != em[u][i]) d++;
    return d;
  endfunction

  // Reference draw: walks the sprite pixel by pixel, updates the expected
  // screen of unit u (0 = clipping, 1 = wrapping) and returns the cycles
  // from the start edge to the done edge, the write count and VF.
  task automatic model_draw(input int u, output int cyc, output int nw, output bit col);
    int rows, wid, x0, y0, px, py;
    bit [7:0] b;
    bit [1:0] old;
    rows = (n == 0) ? 16 : int'(n);
    wid  = (n == 0) ? 16 : 8;
    x0 = int'(x) % 128;
    y0 = int'(y) % 64;
    cyc = 0; nw = 0; col = 1'b0;
    for (int r = 0; r < rows; r++) begin
      cyc += (wid == 16) ? 4 : 2;
      for (int c = 0; c < wid; c++) begin
        if (wid == 16) b = ram[12'(int'(i_addr) + 2 * r + c / 8)];
        else           b = ram[12'(int'(i_addr) + r)];
        px = x0 + c;
        py = y0 + r;
        if (b[7 - (c % 8)] == 1'b0 || (u == 0 && (px >= 128 || py >= 64))) begin
          cyc += 1;
        end else begin
          px = px % 128;
          py = py % 64;
          old = em[u][py * 128 + px];
          if ((old & pmask) != 2'b00) col = 1'b1;
          em[u][py * 128 + px] = old ^ pmask;
          nw++;
          cyc += 3;
        end
      end
    end
  endtask

  // Issues one draw with the current command and checks both units.
  task automatic run_draw(input string tag);
    int ecyc[2], enw[2], w0[2], tdone[2], ndone[2], kmax;
    bit ecol[2], cdone[2];
    for (int u = 0; u < 2; u++) begin
      model_draw(u, ecyc[u], enw[u], ecol[u]);
      w0[u] = int'(wcnt[u]);
      tdone[u] = -1; ndone[u] = 0; cdone[u] = 1'b0;
    end
    kmax = ((ecyc[0] > ecyc[1]) ? ecyc[0] : ecyc[1]) + 4;
    if (kmax > 1000) kmax = 1000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (rd_busy(u) !== 1'b1) begin
        errors++; $display("FAIL %s busy_after_start u%0d: got %b want 1", tag, u, rd_busy(u));
      end
      checks++;
      if (rd_coll(u) !== 1'b0) begin
        errors++; $display("FAIL %s coll_clear u%0d: got %b want 0", tag, u, rd_coll(u));
      end
    end
    for (int k = 1; k <= kmax; k++) begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
        if (rd_done(u) === 1'b1) begin
          ndone[u]++;
          if (tdone[u] < 0) begin
            tdone[u] = k;
            cdone[u] = rd_coll(u);
          end
        end
      end
    end
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (tdone[u] != ecyc[u]) begin
        errors++; $display("FAIL %s done_cycle u%0d: got %0d want %0d", tag, u, tdone[u], ecyc[u]);
      end
      checks++;
      if (ndone[u] != 1) begin
        errors++; $display("FAIL %s done_pulses u%0d: got %0d want 1", tag, u, ndone[u]);
      end
      checks++;
      if (int'(wcnt[u]) - w0[u] != enw[u]) begin
        errors++; $display("FAIL %s writes u%0d: got %0d want %0d", tag, u, int'(wcnt[u]) - w0[u], enw[u]);
      end
      checks++;
      if (cdone[u] !== ecol[u]) begin
        errors++; $display("FAIL %s collision u%0d: got %b want %b", tag, u, cdone[u], ecol[u]);
      end
      checks++;
      if (vram_diff(u) != 0) begin
        errors++; $display("FAIL %s vram u%0d: got %0d differing pixels want 0", tag, u, vram_diff(u));
      end
      checks++;
      if (rd_busy(u) !== 1'b0) begin
        errors++; $display("FAIL %s busy_idle u%0d: got %b want 0", tag, u, rd_busy(u));
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({rd_busy(u), rd_done(u), rd_coll(u), rd_we(u)} !== 4'b0000) begin
        errors++; $display("FAIL reset_flags u%0d: got %b want 0000", u,
                           {rd_busy(u), rd_done(u), rd_coll(u), rd_we(u)});
      end
      checks++;
      if ({rd_raddr(u), rd_hpos(u), rd_vpos(u)} !== 25'd0) begin
        errors++; $display("FAIL reset_addr u%0d: got %h/%h/%h want 0", u,
                           rd_raddr(u), rd_hpos(u), rd_vpos(u));
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_pixel;
    ram[12'h200] = 8'h80;
    x = 7'd0; y = 6'd0; n = 4'd1; i_addr = 12'h200; pmask = 2'b01;
    run_draw("single");
  endtask

  task automatic test_collision;
    run_draw("collide");
    run_draw("recollide");
  endtask

  task automatic test_clip_wrap;
    ram[12'h300] = 8'hFF;
    x = 7'd125; y = 6'd63; n = 4'd1; i_addr = 12'h300; pmask = 2'b01;
    run_draw("edge125");
    x = 7'(253);
    run_draw("edge253");
  endtask

  task automatic test_16x16;
    for (int i = 0; i < 32; i++) ram[12'h400 + 12'(i)] = 8'hFF;
    x = 7'd8; y = 6'd8; n = 4'd0; i_addr = 12'h400; pmask = 2'b11;
    run_draw("wide16");
  endtask

  task automatic test_back_to_back;
    int ecyc[2], enw[2], w0[2], ndone[2], tdone, late_busy;
    bit ecol[2];
    x = 7'd40; y = 6'd20; n = 4'd1; i_addr = 12'h200; pmask = 2'b10;
    for (int u = 0; u < 2; u++) begin
      model_draw(u, ecyc[u], enw[u], ecol[u]);
      w0[u] = int'(wcnt[u]);
      ndone[u] = 0;
    end
    tdone = -1; late_busy = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    x = 7'd99;            // must not be latched: the unit is busy
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 4; k <= 60; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (tdone > 0 && k > tdone && (rd_busy(0) !== 1'b0 || rd_busy(1) !== 1'b0)) late_busy++;
      for (int u = 0; u < 2; u++) if (rd_done(u) === 1'b1) ndone[u]++;
      if (rd_done(0) === 1'b1 && tdone < 0) begin
        tdone = k;
        start = 1'b1;     // arrives while still in DONE
      end
    end
    checks++;
    if (tdone != ecyc[0]) begin
      errors++; $display("FAIL b2b done_cycle: got %0d want %0d", tdone, ecyc[0]);
    end
    checks++;
    if (late_busy != 0) begin
      errors++; $display("FAIL b2b start_in_done: got %0d busy cycles want 0", late_busy);
    end
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (ndone[u] != 1) begin
        errors++; $display("FAIL b2b done_pulses u%0d: got %0d want 1", u, ndone[u]);
      end
      checks++;
      if (int'(wcnt[u]) - w0[u] != enw[u]) begin
        errors++; $display("FAIL b2b writes u%0d: got %0d want %0d", u, int'(wcnt[u]) - w0[u], enw[u]);
      end
      checks++;
      if (vram_diff(u) != 0) begin
        errors++; $display("FAIL b2b vram u%0d: got %0d differing pixels want 0", u, vram_diff(u));
      end
    end
  endtask

  task automatic test_reset_mid_draw;
    int w0[2], ndone;
    // mask 0 leaves pixel data unchanged, so the aborted draw keeps the
    // expected screen exact however far it got
    x = 7'd8; y = 6'd8; n = 4'd0; i_addr = 12'h400; pmask = 2'b00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({rd_busy(u), rd_we(u), rd_done(u)} !== 3'b000) begin
        errors++; $display("FAIL abort_flags u%0d: got %b want 000", u, {rd_busy(u), rd_we(u), rd_done(u)});
      end
      checks++;
      if ({rd_raddr(u), rd_hpos(u)} !== 19'd0) begin
        errors++; $display("FAIL abort_addr u%0d: got %h/%h want 0", u, rd_raddr(u), rd_hpos(u));
      end
      w0[u] = int'(wcnt[u]);
    end
    ndone = 0;
    for (int k = 0; k < 900; k++) begin
      @(posedge clk); #1;
      if (rd_done(0) === 1'b1 || rd_done(1) === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone);
    end
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (int'(wcnt[u]) != w0[u] || vram_diff(u) != 0) begin
        errors++; $display("FAIL abort_quiet u%0d: got %0d writes, %0d diffs want 0", u,
                           int'(wcnt[u]) - w0[u], vram_diff(u));
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    for (int t = 0; t < 8; t++) begin
      x = 7'($urandom_range(0, 127));
      y = 6'($urandom_range(0, 63));
      n = 4'($urandom_range(0, 15));
      i_addr = (t % 3 == 0) ? 12'(12'hFF0 + $urandom_range(0, 15)) : 12'($urandom);
      pmask = 2'($urandom_range(0, 3));
      run_draw($sformatf("rand%0d", t));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0;
    x = '0; y = '0; n = '0; i_addr = '0; pmask = '0;
    test_reset();
    test_single_pixel();
    test_collision();
    test_clip_wrap();
    test_16x16();
    test_back_to_back();
    test_reset_mid_draw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
